// File: rtl/hpi_pkg.sv
// hpi_pkg: state encoding and HPI register map shared by the HPI sequencer
package hpi_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    GAP,
    D_SETUP,
    D_STROBE,
    D_HOLD,
    RESP
  } state_t;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  localparam logic [15:0] ADDR_INC = 16'd2;

endpackage

// File: rtl/hpi_sequencer.sv
// hpi_sequencer: turns single-word requests into timed CY7C67200 HPI bus cycles
module hpi_sequencer
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_reg,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  sw_address,
  output logic [15:0] sw_data_out,
  input  logic [15:0] sw_data_in,
  output logic        sw_r,
  output logic        sw_w,
  output logic        sw_cs
);

  localparam logic [3:0] SETUP_LD    = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD   = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD     = 4'(HOLD_CYC - 1);
  localparam logic [3:0] CAPTURE_CNT = 4'(HOLD_CYC - 2);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_ld;
  logic        lat_write, lat_reg;
  logic [15:0] lat_addr, lat_wdata;
  logic [15:0] shadow;
  logic        addr_valid;
  logic        accept, skip_addr, phase_done, data_done;
  logic        addr_ph, data_ph;

  assign accept     = req_valid && req_ready;
  assign skip_addr  = req_reg || (addr_valid && req_addr == shadow);
  assign phase_done = cnt == 4'd0;
  assign data_done  = state == D_HOLD && phase_done;

  // State register plus phase counter, reloaded whenever a new phase is entered
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? cnt_ld : cnt - 4'd1;
    end
  end

  // Next-state sequencing; the GAP state returns CS/strobes high between phases
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = skip_addr ? D_SETUP : A_SETUP;
      A_SETUP:  if (phase_done) state_nxt = A_STROBE;
      A_STROBE: if (phase_done) state_nxt = A_HOLD;
      A_HOLD:   if (phase_done) state_nxt = GAP;
      GAP:      state_nxt = D_SETUP;
      D_SETUP:  if (phase_done) state_nxt = D_STROBE;
      D_STROBE: if (phase_done) state_nxt = D_HOLD;
      D_HOLD:   if (phase_done) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    cnt_ld = (state_nxt inside {A_SETUP, D_SETUP})   ? SETUP_LD  :
             (state_nxt inside {A_STROBE, D_STROBE}) ? STROBE_LD :
             (state_nxt inside {A_HOLD, D_HOLD})     ? HOLD_LD   : 4'd0;
  end

  // Bus outputs decoded from state and the latched request
  always_comb begin
    addr_ph     = state inside {A_SETUP, A_STROBE, A_HOLD};
    data_ph     = state inside {D_SETUP, D_STROBE, D_HOLD};
    sw_cs       = !(addr_ph || data_ph);
    sw_w        = !(state == A_STROBE || (state == D_STROBE && lat_write));
    sw_r        = !(state == D_STROBE && !lat_write);
    sw_address  = addr_ph ? HPI_ADDR : (data_ph && lat_reg) ? lat_addr[1:0] : HPI_DATA;
    sw_data_out = addr_ph ? lat_addr : (data_ph && lat_write) ? lat_wdata : 16'h0000;
    req_ready   = state == IDLE;
    rsp_valid   = state == RESP;
  end

  // Request fields are held for the whole transaction
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      lat_write <= 1'b0;
      lat_reg   <= 1'b0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
    end else if (accept) begin
      lat_write <= req_write;
      lat_reg   <= req_reg;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Read data arrives through a 2-cycle registered path, so sample at the 2nd hold cycle
  always_ff @(posedge Clk) begin
    if (!Reset_N)
      rsp_rdata <= 16'h0000;
    else if (state == D_HOLD && cnt == CAPTURE_CNT && !lat_write)
      rsp_rdata <= sw_data_in;
  end

  // Mirror of the chip's auto-incrementing address register
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      shadow     <= 16'h0000;
      addr_valid <= 1'b0;
    end else if (data_done) begin
      if (!lat_reg) begin
        shadow     <= lat_addr + ADDR_INC;
        addr_valid <= 1'b1;
      end else if (lat_addr[1:0] == HPI_ADDR && lat_write) begin
        shadow     <= lat_wdata;
        addr_valid <= 1'b1;
      end else if (lat_addr[1:0] == HPI_DATA && addr_valid) begin
        shadow <= shadow + ADDR_INC;
      end
    end
  end

endmodule

// File: tb/tb_hpi_sequencer.sv
// tb_hpi_sequencer: scoreboard bench driving hpi_sequencer into an HPI pipeline and chip model
`timescale 1ns/1ps
module tb_hpi_sequencer;

  localparam int N = 3;
  localparam int SET [N] = '{1, 1, 15};
  localparam int STB [N] = '{4, 1, 15};
  localparam int HLD [N] = '{2, 2, 15};

  typedef struct {
    int          inst;
    logic        rd;
    logic [15:0] rdata;
    int          lat;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic        rv [N], rw [N], rg [N];
  logic [15:0] ra [N], rwd [N];
  logic        rdy [N], rspv [N];
  logic [15:0] rsd [N];
  logic [1:0]  swa [N];
  logic [15:0] swdo [N], swdi [N];
  logic        swr [N], sww [N], swcs [N];

  logic        p_cs [N], p_r [N], p_w [N], pr_d [N], pw_d [N];
  logic [1:0]  p_a [N];
  logic [15:0] p_d [N], haddr [N], mbox [N];
  logic [15:0] mem [N][65536];

  int          a_cnt [N], w_run [N], r_run [N], w_width [N], r_width [N];
  logic [1:0]  w_addr [N], r_addr [N];
  logic [15:0] a_data [N];
  logic        sww_d [N], swr_d [N];
  int          acc_cyc [N];

  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    hpi_sequencer #(.SETUP_CYC(SET[g]), .STROBE_CYC(STB[g]), .HOLD_CYC(HLD[g])) dut (
      .Clk        (Clk),
      .Reset_N    (Reset_N),
      .req_valid  (rv[g]),
      .req_ready  (rdy[g]),
      .req_write  (rw[g]),
      .req_reg    (rg[g]),
      .req_addr   (ra[g]),
      .req_wdata  (rwd[g]),
      .rsp_valid  (rspv[g]),
      .rsp_rdata  (rsd[g]),
      .sw_address (swa[g]),
      .sw_data_out(swdo[g]),
      .sw_data_in (swdi[g]),
      .sw_r       (swr[g]),
      .sw_w       (sww[g]),
      .sw_cs      (swcs[g])
    );
  end

  // I/O interface (one register stage each way) and CY7C67200 HPI model
  always @(posedge Clk) begin
    for (int i = 0; i < N; i++) begin
      p_cs[i] <= Reset_N ? swcs[i] : 1'b1;
      p_r[i]  <= Reset_N ? swr[i] : 1'b1;
      p_w[i]  <= Reset_N ? sww[i] : 1'b1;
      p_a[i]  <= swa[i];
      p_d[i]  <= swdo[i];
      pr_d[i] <= Reset_N ? p_r[i] : 1'b1;
      pw_d[i] <= Reset_N ? p_w[i] : 1'b1;
      swdi[i] <= (p_a[i] == 2'd0) ? mem[i][haddr[i][15:1]] :
                 (p_a[i] == 2'd1) ? mbox[i] :
                 (p_a[i] == 2'd2) ? haddr[i] : 16'h0005;
      if (!p_cs[i] && !p_w[i] && pw_d[i]) begin
        if (p_a[i] == 2'd2) haddr[i] <= p_d[i];
        else if (p_a[i] == 2'd1) mbox[i] <= p_d[i];
        else if (p_a[i] == 2'd0) begin
          mem[i][haddr[i][15:1]] <= p_d[i];
          haddr[i] <= haddr[i] + 16'd2;
        end
      end
      if (!p_cs[i] && p_r[i] && !pr_d[i] && p_a[i] == 2'd0) haddr[i] <= haddr[i] + 16'd2;
    end
  end

  // Bus observer: address phases, strobe widths, data-phase addresses
  always @(negedge Clk) begin
    for (int i = 0; i < N; i++) begin
      if (!Reset_N) begin
        a_cnt[i] <= 0; w_run[i] <= 0; r_run[i] <= 0; w_width[i] <= 0; r_width[i] <= 0;
        w_addr[i] <= 2'd0; r_addr[i] <= 2'd0; a_data[i] <= 16'h0; sww_d[i] <= 1'b1; swr_d[i] <= 1'b1;
      end else begin
        if (!sww[i] && sww_d[i]) begin
          w_addr[i] <= swa[i];
          if (swa[i] == 2'd2) begin
            a_cnt[i]  <= a_cnt[i] + 1;
            a_data[i] <= swdo[i];
          end
        end
        if (!swr[i] && swr_d[i]) r_addr[i] <= swa[i];
        if (!sww[i]) w_run[i] <= w_run[i] + 1;
        else if (w_run[i] != 0) begin w_width[i] <= w_run[i]; w_run[i] <= 0; end
        if (!swr[i]) r_run[i] <= r_run[i] + 1;
        else if (r_run[i] != 0) begin r_width[i] <= r_run[i]; r_run[i] <= 0; end
        sww_d[i] <= sww[i];
        swr_d[i] <= swr[i];
      end
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge Clk);
      for (int i = 0; i < N; i++) begin
        if (rv[i] && rdy[i]) acc_cyc[i] = cyc;
        if (rspv[i]) begin
          if (sb.size() == 0 || sb[0].inst != i) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: inst %0d gave rsp_valid with nothing expected", i);
          end else begin
            e = sb.pop_front();
            if (e.rd) check($sformatf("rsp_rdata[%0d]", i), int'(rsd[i]), int'(e.rdata));
            if (e.lat != 0) check($sformatf("latency[%0d]", i), cyc - acc_cyc[i] + 1, e.lat);
          end
        end
      end
    end
  endtask

  task automatic do_req(input int i, input bit w, input bit g, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] x, input int lat);
    int n;
    n = 0;
    while (!rdy[i] && n < 200) begin @(posedge Clk); #1; n++; end
    rv[i] = 1'b1; rw[i] = w; rg[i] = g; ra[i] = a; rwd[i] = d;
    sb.push_back('{inst: i, rd: !w, rdata: x, lat: lat});
    @(posedge Clk); #1;
    rv[i] = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 500) begin @(posedge Clk); #1; n++; end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: inst %0d got no rsp_valid, required one", i);
      sb.delete();
    end
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; rg[i] = 1'b0; ra[i] = 16'h0; rwd[i] = 16'h0;
    end
    fork monitor(); join_none
    repeat (3) @(posedge Clk);
    #1 Reset_N = 1'b1;
    check("reset_cs", swcs[0], 1);
    check("reset_r", swr[0], 1);
    check("reset_w", sww[0], 1);
    check("reset_ready", rdy[0], 1);
    check("reset_rspv", rspv[0], 0);
    check("reset_rdata", rsd[0], 0);
    check("reset_addr", swa[0], 0);
    check("reset_dout", swdo[0], 0);

    do_req(0, 1, 0, 16'h0F00, 16'h0BAD, 16'h0, 17);
    rv[0] = 1'b1; rw[0] = 1'b1; rg[0] = 1'b0; ra[0] = 16'h1000; rwd[0] = 16'hBEEF;
    @(posedge Clk); #1;
    rv[0] = 1'b0;
    n = 0;
    while (!(sww[0] == 1'b0 && swa[0] == 2'd2) && n < 20) begin @(posedge Clk); #1; n++; end
    check("reached_a_strobe", n < 20, 1);
    Reset_N = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset_N = 1'b1;
    check("midrst_cs", swcs[0], 1);
    check("midrst_r", swr[0], 1);
    check("midrst_w", sww[0], 1);
    check("midrst_ready", rdy[0], 1);
    repeat (20) @(posedge Clk);
    #1;

    base = a_cnt[0];
    do_req(0, 1, 0, 16'h0F02, 16'h0C0D, 16'h0, 17);
    check("skip_disabled_after_reset", a_cnt[0] - base, 1);
    check("mem_0f02", mem[0][16'h0F02 >> 1], 16'h0C0D);

    base = a_cnt[0];
    do_req(0, 1, 0, 16'h1000, 16'hBEEF, 16'h0, 17);
    check("wr1000_aphase", a_cnt[0] - base, 1);
    check("wr1000_adata", a_data[0], 16'h1000);
    check("wr1000_daddr", w_addr[0], 0);
    check("wr1000_strobe", w_width[0], 4);
    check("mem_1000", mem[0][16'h1000 >> 1], 16'hBEEF);
    base = a_cnt[0];
    do_req(0, 0, 0, 16'h1000, 16'h0, 16'hBEEF, 17);
    check("rd1000_aphase", a_cnt[0] - base, 1);
    check("rd1000_daddr", r_addr[0], 0);
    check("rd1000_strobe", r_width[0], 4);

    base = a_cnt[0];
    do_req(0, 1, 0, 16'h2000, 16'h1111, 16'h0, 17);
    do_req(0, 1, 0, 16'h2002, 16'h2222, 16'h0, 9);
    do_req(0, 1, 0, 16'h2004, 16'h3333, 16'h0, 9);
    check("seq_aphase", a_cnt[0] - base, 1);
    check("mem_2000", mem[0][16'h2000 >> 1], 16'h1111);
    check("mem_2002", mem[0][16'h2002 >> 1], 16'h2222);
    check("mem_2004", mem[0][16'h2004 >> 1], 16'h3333);

    base = a_cnt[0];
    do_req(0, 1, 0, 16'hFFFE, 16'hAAAA, 16'h0, 17);
    do_req(0, 1, 0, 16'h0000, 16'h5555, 16'h0, 9);
    check("wrap_aphase", a_cnt[0] - base, 1);
    check("mem_fffe", mem[0][16'hFFFE >> 1], 16'hAAAA);
    check("mem_0000", mem[0][0], 16'h5555);

    base = a_cnt[0];
    do_req(0, 0, 1, 16'h0003, 16'h0, 16'h0005, 9);
    check("status_aphase", a_cnt[0] - base, 0);
    check("status_daddr", r_addr[0], 3);
    do_req(0, 1, 0, 16'h0002, 16'h7777, 16'h0, 9);
    check("status_keeps_shadow", a_cnt[0] - base, 0);
    check("mem_0002", mem[0][1], 16'h7777);

    do_req(0, 1, 0, 16'h3000, 16'h4444, 16'h0, 17);
    do_req(0, 1, 1, 16'h0002, 16'h3000, 16'h0, 9);
    base = a_cnt[0];
    do_req(0, 0, 0, 16'h3000, 16'h0, 16'h4444, 9);
    check("hpiaddr_write_skip", a_cnt[0] - base, 0);

    do_req(1, 1, 0, 16'h0100, 16'h1234, 16'h0, 11);
    check("min_w_strobe", w_width[1], 1);
    do_req(1, 0, 0, 16'h0100, 16'h0, 16'h1234, 11);
    check("min_r_strobe", r_width[1], 1);

    do_req(2, 1, 0, 16'h0200, 16'hCAFE, 16'h0, 93);
    check("max_w_strobe", w_width[2], 15);
    do_req(2, 0, 0, 16'h0200, 16'h0, 16'hCAFE, 93);
    check("max_r_strobe", r_width[2], 15);

    repeat (5) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
